// File: rtl/mf_cfg_sequencer_if.sv
// Bus bundle between the configuration host / receive chain and the match-filter sequencer.
// Handshake: a word moves on every rising clk edge where cfg_valid & cfg_ready are both 1.
interface mf_cfg_sequencer_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        rxstrobe_in;
  logic        rxstrobe_out;
  logic [31:0] cdata;
  logic [2:0]  cstate;
  logic        cwrite;
  logic        mf_valid;
  logic        mf_match;

  modport master (
    output cfg_data, cfg_valid, rxstrobe_in, mf_valid, mf_match,
    input  cfg_ready, rxstrobe_out, cdata, cstate, cwrite
  );

  modport slave (
    input  cfg_data, cfg_valid, rxstrobe_in, mf_valid, mf_match,
    output cfg_ready, rxstrobe_out, cdata, cstate, cwrite
  );
endinterface

// File: rtl/mf_cfg_sequencer.sv
// Loads NUM_WORDS configuration words into the match filter once the receive strobe has
// been quiet long enough, gates strobes while configuring, and keeps result statistics.
module mf_cfg_sequencer #(
  parameter int NUM_WORDS    = 8,
  parameter int QUIET_CYCLES = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  mf_cfg_sequencer_if.slave   bus,
  input  logic                count_clr,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                busy,
  output logic [15:0]         match_count,
  output logic [15:0]         result_count,
  output logic [7:0]          drop_count,
  output logic [1:0]          dbg_state_o
);
  localparam int QW = (QUIET_CYCLES < 2) ? 1 : $clog2(QUIET_CYCLES + 1);
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0]    LAST_IDX    = 3'(NUM_WORDS - 1);
  localparam logic [QW-1:0] QUIET_LOAD  = QW'(QUIET_CYCLES);
  localparam logic [IW-1:0] TIMEOUT_VAL = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_QUIET = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   cdata_q, cdata_d;
  logic [2:0]    cstate_q, cstate_d;
  logic          cwrite_q, cwrite_d;
  logic          cfg_error_q, cfg_error_d;
  logic [15:0]   match_q, match_d;
  logic [15:0]   result_q, result_d;
  logic [7:0]    drop_q, drop_d;
  logic          fwd, hs;

  // Strobes only reach the filter while it is idle and out of reset.
  assign fwd = bus.rxstrobe_in & reset & (state_q == IDLE);
  assign hs  = bus.cfg_valid & (state_q == WRITE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idle_d      = '0;
    cdata_d     = cdata_q;
    cstate_d    = cstate_q;
    cwrite_d    = 1'b0;
    cfg_error_d = 1'b0;
    quiet_d     = fwd ? QUIET_LOAD : ((quiet_q != '0) ? quiet_q - QW'(1) : '0);

    case (state_q)
      IDLE:       if (bus.cfg_valid) state_d = WAIT_QUIET;
      // Enter WRITE in the cycle the quiet counter lands on zero.
      WAIT_QUIET: if (quiet_d == '0) state_d = WRITE;
      WRITE: begin
        if (hs) begin
          cwrite_d = 1'b1;
          cdata_d  = bus.cfg_data;
          cstate_d = idx_q;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (idle_q + IW'(1) == TIMEOUT_VAL) begin
          cfg_error_d = 1'b1;
          idx_d       = '0;
          state_d     = IDLE;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    match_d  = match_q;
    result_d = result_q;
    drop_d   = drop_q;
    if (count_clr) begin
      match_d  = '0;
      result_d = '0;
      drop_d   = '0;
    end else begin
      if (bus.mf_valid && result_q != 16'hFFFF) result_d = result_q + 16'd1;
      if (bus.mf_valid && bus.mf_match && match_q != 16'hFFFF) match_d = match_q + 16'd1;
      if (bus.rxstrobe_in && state_q != IDLE && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      quiet_q     <= '0;
      idle_q      <= '0;
      idx_q       <= '0;
      cdata_q     <= '0;
      cstate_q    <= '0;
      cwrite_q    <= 1'b0;
      cfg_error_q <= 1'b0;
      match_q     <= '0;
      result_q    <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      quiet_q     <= quiet_d;
      idle_q      <= idle_d;
      idx_q       <= idx_d;
      cdata_q     <= cdata_d;
      cstate_q    <= cstate_d;
      cwrite_q    <= cwrite_d;
      cfg_error_q <= cfg_error_d;
      match_q     <= match_d;
      result_q    <= result_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.cfg_ready    = (state_q == WRITE);
  assign bus.rxstrobe_out = fwd;
  assign bus.cdata        = cdata_q;
  assign bus.cstate       = cstate_q;
  assign bus.cwrite       = cwrite_q;
  assign cfg_done         = (state_q == DONE);
  assign cfg_error        = cfg_error_q;
  assign busy             = (state_q != IDLE);
  assign match_count      = match_q;
  assign result_count     = result_q;
  assign drop_count       = drop_q;
  assign dbg_state_o      = state_q;
endmodule

// File: doc/mf_cfg_sequencer.md
MF_CFG_SEQUENCER -- requirements
Module: mf_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 8, the number of configuration words per load sequence (cstate 0..NUM_WORDS-1).
REQ-002 SHALL have parameter QUIET_CYCLES, default 8, the number of cycles the filter stays busy after each forwarded rxstrobe.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of idle cycles allowed between words inside a sequence.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port cfg_data, input, 32 bits: configuration word from the host.
REQ-007 SHALL have port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the sequencer accepts cfg_data this cycle.
REQ-009 SHALL have port rxstrobe_in, input, 1 bit: sample strobe from the receive chain.
REQ-010 SHALL have port rxstrobe_out, output, 1 bit: gated strobe to the match filter.
REQ-011 SHALL have ports cdata (output, 32 bits), cstate (output, 3 bits) and cwrite (output, 1 bit): the filter configuration write bus.
REQ-012 SHALL have ports mf_valid and mf_match, inputs, 1 bit each: the filter result strobe and its match flag.
REQ-013 SHALL have ports cfg_done and cfg_error, outputs, 1 bit each: one-cycle pulses marking sequence completion and sequence abort.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have ports match_count and result_count, outputs, 16 bits each; drop_count, output, 8 bits; and count_clr, input, 1 bit.

Function
REQ-016 SHALL implement the states IDLE, WAIT_QUIET, WRITE and DONE.
REQ-017 IDLE:
- cfg_valid=1 transitions to WAIT_QUIET.
- No word is consumed on that transition.
REQ-018 Quiet counter:
- Loaded with QUIET_CYCLES on every forwarded strobe (rxstrobe_out=1).
- Otherwise decrements toward 0 and saturates at 0.
REQ-019 WAIT_QUIET transitions to WRITE on the first cycle in which the quiet counter is 0.
REQ-020 In WRITE, cfg_ready SHALL equal 1 combinationally; it is 0 in all other states.
REQ-021 On a WRITE handshake (cfg_valid & cfg_ready), in the next cycle:
- cwrite=1.
- cdata = the accepted word.
- cstate = the word index, starting at 0 and incrementing per handshake.
REQ-022 cwrite SHALL be 0 in every cycle that does not follow a handshake; cdata and cstate hold their last values.
REQ-023 Handshake of word NUM_WORDS-1 transitions to DONE; DONE lasts exactly one cycle, during which cfg_done=1, and then returns to IDLE.
REQ-024 Timeout:
- In WRITE, an idle counter increments on each cycle without a handshake and clears on each handshake.
- When the counter reaches TIMEOUT: cfg_error=1 for one cycle, return to IDLE, word index reset to 0, cfg_done not asserted.
REQ-025 Strobe gating:
- rxstrobe_out = rxstrobe_in & (state==IDLE), combinationally.
- Strobes arriving in WAIT_QUIET, WRITE or DONE are suppressed.
REQ-026 drop_count SHALL increment on each suppressed strobe, saturating at 255.
REQ-027 If rxstrobe_in and cfg_valid arrive in the same IDLE cycle, the strobe is forwarded, the quiet counter loads QUIET_CYCLES, and the state goes to WAIT_QUIET.
REQ-028 result_count SHALL increment on each mf_valid, saturating at 0xFFFF.
REQ-029 match_count SHALL increment on each mf_valid & mf_match, saturating at 0xFFFF.
REQ-030 count_clr=1 SHALL zero match_count, result_count and drop_count next cycle; it takes priority over a simultaneous increment.
REQ-031 The counters SHALL count in every state; configuration does not stop counting.

Reset
REQ-032 With reset=0 at a clock edge, the block SHALL enter IDLE, with all of the following set to 0:
- cwrite, cstate, cdata, cfg_done, cfg_error.
- Word index, quiet counter, idle counter.
- All three counters.
REQ-033 Reset asserted mid-sequence (WAIT_QUIET/WRITE/DONE) SHALL abort without asserting cfg_done or cfg_error; the filter is left partially configured and the host reloads it.
REQ-034 While reset=0, rxstrobe_out SHALL be 0.

Verification
REQ-035 Idle load: no strobes; cfg_valid held high with words 0x1000_0000..0x1000_0007 -> WRITE entered after 1 cycle; cwrite pulses on 8 consecutive cycles with cstate 0..7 and the matching cdata; cfg_done in the cycle of the last cwrite; then IDLE.
REQ-036 Quiet wait: rxstrobe_in at cycle 0 and cfg_valid at cycle 0 -> strobe forwarded; cfg_ready first high at cycle 9; strobes at cycles 3 and 12 suppressed; drop_count=2.
REQ-037 Timeout: 3 words accepted, then cfg_valid=0 for 255 cycles -> cfg_error pulse, IDLE, cfg_done never asserted; the next sequence starts at cstate 0.
REQ-038 Counting: 300 mf_valid pulses with mf_match on every third -> result_count=300, match_count=100; count_clr coincident with an mf_valid -> both counters 0.
REQ-039 Saturation/reset: 70000 mf_valid&mf_match pulses -> match_count=0xFFFF; reset=0 during WRITE after word 4 -> next cycle IDLE with cwrite=0, busy=0, all counters 0.
